layer_seq_ctrl: RTL and testbench

Top-level layer scheduler for the LeNet accelerator. Steps the network through C1→S2→C3→S4→C5→FC→OL and drives the 3-bit `layer_signal` consumed by the BRAM-to-core fetch controller. For each layer it:
- counts the parameter words written into the weight FIFO;
- withdraws the layer code once the expected count is reached;
- waits for the compute core to report the layer finished.

A watchdog flags a core that never completes.

---
 rtl/layer_seq_ctrl_pkg.sv | 21 ++
 rtl/layer_seq_ctrl_wdog_cnt.sv | 37 +++
 rtl/layer_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_ctrl_pkg.sv
// Shared layer codes and controller state encoding for the LeNet layer scheduler.
// Layer codes are consumed unchanged by the fetch controller and the compute core.
package layer_seq_ctrl_pkg;

  localparam logic [2:0] L_IDLE = 3'd0;
  localparam logic [2:0] L_C1   = 3'd1;
  localparam logic [2:0] L_S2   = 3'd2;
  localparam logic [2:0] L_C3   = 3'd3;
  localparam logic [2:0] L_S4   = 3'd4;
  localparam logic [2:0] L_C5   = 3'd5;
  localparam logic [2:0] L_FC   = 3'd6;
  localparam logic [2:0] L_OL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_CORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/layer_seq_ctrl_wdog_cnt.sv
// Clearable up-counter with a terminal-count flag, used as the core-completion watchdog.
// The flag is raised combinationally on the last allowed cycle so the caller can act on it.
module wdog_cnt #(
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            at_limit;

  assign at_limit = (cnt_q == TO_W'(TIMEOUT - 1));
  assign tc_o     = en_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Steps the network C1..OL: fetch each layer's parameter words, then wait for the core.
// All outputs are registered copies of the next-state decode.
module layer_seq_ctrl
  import layer_seq_ctrl_pkg::*;
#(
  parameter int N_C1    = 2,
  parameter int N_C3    = 4,
  parameter int N_C5    = 24,
  parameter int N_FC    = 17,
  parameter int N_OL    = 2,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       fetch_wr,
  input  logic       core_done,
  output logic [2:0] layer_signal,
  output logic [2:0] cur_layer,
  output logic       layer_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  function automatic logic [CNT_W-1:0] words_for(input logic [2:0] layer);
    case (layer)
      L_C1:    words_for = CNT_W'(N_C1);
      L_C3:    words_for = CNT_W'(N_C3);
      L_C5:    words_for = CNT_W'(N_C5);
      L_FC:    words_for = CNT_W'(N_FC);
      L_OL:    words_for = CNT_W'(N_OL);
      default: words_for = '0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cur_layer_q, cur_layer_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] need;
  logic             err_q, err_d;
  logic [2:0]       layer_signal_q, layer_signal_d;
  logic             layer_start_q, layer_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wd_clr, wd_tc;

  wdog_cnt #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(wd_clr),
    .en_i (state_q == ST_WAIT_CORE),
    .tc_o (wd_tc)
  );

  assign need = words_for(cur_layer_q);

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    word_cnt_d  = word_cnt_q;
    err_d       = err_q;
    wd_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          cur_layer_d = L_C1;
          word_cnt_d  = '0;
          err_d       = 1'b0;
        end
      end
      ST_LOAD: begin
        // Pooling layers carry no parameters: a single LOAD cycle announces them.
        if (need == '0) begin
          state_d = ST_WAIT_CORE;
          wd_clr  = 1'b1;
        end else if (fetch_wr) begin
          if (word_cnt_q == need - CNT_W'(1)) begin
            state_d = ST_WAIT_CORE;
            wd_clr  = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_CORE: begin
        if (wd_tc) begin
          state_d     = ST_IDLE;
          cur_layer_d = L_IDLE;
          err_d       = 1'b1;
        end else if (core_done) begin
          if (cur_layer_q == L_OL) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_LOAD;
            cur_layer_d = cur_layer_q + 3'd1;
            word_cnt_d  = '0;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cur_layer_d = L_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      cur_layer_d = L_IDLE;
      word_cnt_d  = '0;
      err_d       = err_q;
      wd_clr      = 1'b0;
    end

    layer_signal_d = (state_d == ST_LOAD) ? cur_layer_d : L_IDLE;
    layer_start_d  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cur_layer_q    <= L_IDLE;
      word_cnt_q     <= '0;
      err_q          <= 1'b0;
      layer_signal_q <= L_IDLE;
      layer_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_layer_q    <= cur_layer_d;
      word_cnt_q     <= word_cnt_d;
      err_q          <= err_d;
      layer_signal_q <= layer_signal_d;
      layer_start_q  <= layer_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign layer_signal = layer_signal_q;
  assign cur_layer    = cur_layer_q;
  assign layer_start  = layer_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the layer schedule.
module tb_layer_seq_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       fetch_wr = 1'b0;
  logic       core_done = 1'b0;
  logic [2:0] layer_signal, cur_layer;
  logic       layer_start, busy, done, err;

  always #5 clk = ~clk;

  layer_seq_ctrl #(
    .N_C1(2), .N_C3(4), .N_C5(24), .N_FC(17), .N_OL(2),
    .CNT_W(6), .TIMEOUT(TO), .TO_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fetch_wr(fetch_wr), .core_done(core_done),
    .layer_signal(layer_signal), .cur_layer(cur_layer),
    .layer_start(layer_start), .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int words_taken = 0;

  // Behavioural model: phase 0 idle, 1 fetching, 2 waiting on core, 3 finished.
  int need[8] = '{0, 2, 0, 4, 0, 24, 17, 2};
  int m_phase, m_layer, m_seen, m_waited;
  bit m_start_pulse, m_err;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_layer = 0; m_seen = 0; m_waited = 0;
    m_start_pulse = 0; m_err = 0;
  endtask

  task automatic enter_layer(input int l);
    m_phase = 1; m_layer = l; m_seen = 0; m_start_pulse = 1;
  endtask

  task automatic model_step(input bit s, input bit a, input bit f, input bit d);
    m_start_pulse = 0;
    if (a) begin
      m_phase = 0; m_layer = 0;
    end else begin
      case (m_phase)
        0: if (s) begin enter_layer(1); m_err = 0; end
        1: begin
          if (need[m_layer] == 0) begin
            m_phase = 2; m_waited = 0;
          end else if (f) begin
            m_seen++;
            words_taken++;
            if (m_seen == need[m_layer]) begin m_phase = 2; m_waited = 0; end
          end
        end
        2: begin
          if (m_waited == TO - 1) begin
            m_phase = 0; m_layer = 0; m_err = 1;
          end else if (d) begin
            if (m_layer == 7) m_phase = 3;
            else enter_layer(m_layer + 1);
          end else begin
            m_waited++;
          end
        end
        default: begin m_phase = 0; m_layer = 0; end
      endcase
    end
  endtask

  task automatic compare_all();
    check("layer_signal", int'(layer_signal), (m_phase == 1) ? m_layer : 0);
    check("cur_layer", int'(cur_layer), m_layer);
    check("layer_start", int'(layer_start), int'(m_start_pulse));
    check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    check("done", int'(done), (m_phase == 3) ? 1 : 0);
    check("err", int'(err), int'(m_err));
    if (done === 1'b1) done_seen++;
  endtask

  // Called at a falling edge; drives inputs, advances model at the rising edge, checks at the next fall.
  task automatic cycle(input bit s, input bit a, input bit f, input bit d);
    start = s; abort = a; fetch_wr = f; core_done = d;
    @(posedge clk);
    model_step(s, a, f, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic fetch_layer(input int l);
    if (need[l] == 0) cycle(0, 0, 0, 0);
    else for (int w = 0; w < need[l]; w++) cycle(0, 0, 1, 0);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);

    // Zero-latency core full pass.
    words_taken = 0; done_seen = 0;
    cycle(1, 0, 0, 0);
    for (int l = 1; l <= 7; l++) begin
      fetch_layer(l);
      check("sig_off_after_fetch", int'(layer_signal), 0);
      cycle(0, 0, 0, 1);
    end
    cycle(0, 0, 0, 0);
    check("words_full_pass", words_taken, 49);
    check("done_pulses", done_seen, 1);
    check("busy_after_pass", int'(busy), 0);

    // Watchdog: stall core in C5 wait.
    cycle(1, 0, 0, 0);
    for (int l = 1; l <= 5; l++) begin
      fetch_layer(l);
      if (l < 5) cycle(0, 0, 0, 1);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("err_after_timeout", int'(err), 1);
    cycle(1, 0, 0, 0);
    check("err_cleared_by_start", int'(err), 0);

    // core_done during C3 LOAD ignored; start/extra fetch in S4 ignored; abort+core_done in FC.
    fetch_layer(1); cycle(0, 0, 0, 1);
    fetch_layer(2); cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("c3_load_ignores_done", int'(layer_signal), 3);
    for (int w = 0; w < 3; w++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("c3_waiting", int'(cur_layer), 3);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0);
    check("s4_held", int'(cur_layer), 4);
    cycle(0, 0, 0, 1);
    fetch_layer(5); cycle(0, 0, 0, 1);
    fetch_layer(6);
    done_seen = 0;
    cycle(0, 1, 0, 1);
    check("abort_cur_layer", int'(cur_layer), 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
    check("abort_no_done", done_seen, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
      end
      cycle(($urandom % 6) == 0, ($urandom % 80) == 0,
            $urandom % 2 == 1, ($urandom % 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
